// File: rtl/cos_ctrl.sv
// ----------------------------------------------------------------------------
// cos_ctrl -- control unit for the cosine Maclaurin datapath.
//
// Takes one operand through a start/in_ready handshake and holds it on xBus.
// It then steps the datapath through 8 series terms (MULX -> MULC -> ACC per
// term), captures the accumulator into result and offers it on a
// valid/ready output.
//
// Handshakes: a transfer happens on a rising edge where both sides are high.
//   Input:  start && in_ready  (in_ready only in IDLE)
//   Output: out_valid && out_ready (out_valid only in VALID)
// While out_valid is high, result is held stable.
//
// Ports
//   clk, rst         clock (rising edge), async active-high reset
//   start, x_in      operand request / operand
//   in_ready         ready for a new operand (IDLE)
//   abort            synchronous cancel of a running operation
//   busy             any state other than IDLE
//   out_valid        result valid
//   out_ready        consumer accepts result
//   result           registered result
//   xBus             held operand to the datapath
//   ldX .. cntUp     datapath strobes, Moore-decoded from state
//   cnt8, rBus       datapath term counter == 7, datapath accumulator
//   state_dbg        current FSM state (debug visibility)
// ----------------------------------------------------------------------------
module cos_ctrl #(
   parameter int X_W = 16,
   parameter int R_W = 18
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [X_W-1:0] x_in,
   output logic           in_ready,
   input  logic           abort,
   output logic           busy,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [R_W-1:0] result,
   output logic [X_W-1:0] xBus,
   output logic           ldX,
   output logic           init0,
   output logic           initT1,
   output logic           initC1,
   output logic           ldT,
   output logic           selXR,
   output logic           ldC,
   output logic           cntUp,
   input  logic           cnt8,
   input  logic [R_W-1:0] rBus,
   output logic [2:0]     state_dbg
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MULX  = 3'd2,
      MULC  = 3'd3,
      ACC   = 3'd4,
      CAPT  = 3'd5,
      VALID = 3'd6
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [X_W-1:0] x_hold;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    state_next = MULX;
         MULX:    state_next = MULC;
         MULC:    state_next = ACC;
         ACC:     state_next = cnt8 ? CAPT : MULX;
         CAPT:    state_next = VALID;
         VALID:   if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // abort overrides every other transition, but only once an
      // operation is in flight; in IDLE a concurrent start still wins.
      if (abort && (state != IDLE)) begin
         state_next = IDLE;
      end
   end

   // Moore output decode
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      ldX       = 1'b0;
      init0     = 1'b0;
      initT1    = 1'b0;
      initC1    = 1'b0;
      ldT       = 1'b0;
      selXR     = 1'b0;
      ldC       = 1'b0;
      cntUp     = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         LOAD: begin
            ldX    = 1'b1;
            init0  = 1'b1;
            initT1 = 1'b1;
            initC1 = 1'b1;
         end
         MULX: ldT = 1'b1;
         MULC: begin
            ldT   = 1'b1;
            selXR = 1'b1;
         end
         ACC: begin
            ldC = 1'b1;
            // The last term leaves the counter at 7 so it never wraps.
            cntUp = ~cnt8;
         end
         VALID:   out_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand hold: only an accepted start updates it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_hold <= '0;
      end else if ((state == IDLE) && start) begin
         x_hold <= x_in;
      end
   end

   // Result capture: an abort landing in CAPT leaves the old result intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
      end else if ((state == CAPT) && !abort) begin
         result <= rBus;
      end
   end

   assign xBus      = x_hold;
   assign state_dbg = state;

endmodule

// File: tb/tb_cos_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cos_ctrl -- self-checking bench for cos_ctrl with a behavioural datapath.
//
// The datapath stand-in uses simple integer arithmetic (not a real cosine).
// Each term does T <= 3*T + x, then T <= T + k + 1, then C <= C + T, where k
// is the term index. model_r() recomputes the same series from the operand
// alone, so any sequencing error shows up as a wrong result.
// ----------------------------------------------------------------------------
module tb_cos_ctrl;
  localparam int X_W = 16;
  localparam int R_W = 18;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [X_W-1:0] x_in;
  logic           in_ready;
  logic           abort;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [R_W-1:0] result;
  logic [X_W-1:0] xBus;
  logic           ldX, init0, initT1, initC1, ldT, selXR, ldC, cntUp;
  logic           cnt8;
  logic [R_W-1:0] rBus;
  logic [2:0]     state_dbg;

  cos_ctrl #(.X_W(X_W), .R_W(R_W)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .in_ready(in_ready),
    .abort(abort), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .xBus(xBus), .ldX(ldX), .init0(init0), .initT1(initT1),
    .initC1(initC1), .ldT(ldT), .selXR(selXR), .ldC(ldC), .cntUp(cntUp),
    .cnt8(cnt8), .rBus(rBus), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural datapath ----------------
  logic [X_W-1:0] dp_x;
  logic [R_W-1:0] dp_t, dp_c;
  logic [2:0]     dp_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_x <= '0; dp_t <= '0; dp_c <= '0; dp_cnt <= '0;
    end else begin
      if (ldX) dp_x <= xBus;
      if (init0) begin dp_c <= '0; dp_cnt <= '0; end
      if (initT1) dp_t <= 18'd1;
      if (ldT) dp_t <= selXR ? (dp_t + {15'd0, dp_cnt} + 18'd1)
                             : (dp_t * 18'd3 + {2'b00, dp_x});
      if (ldC) dp_c <= dp_c + dp_t;
      if (cntUp) dp_cnt <= dp_cnt + 3'd1;
    end
  end
  assign cnt8 = (dp_cnt == 3'd7);
  assign rBus = dp_c;

  function automatic logic [R_W-1:0] model_r(input logic [X_W-1:0] x);
    logic [R_W-1:0] t, c;
    t = 18'd1;
    c = '0;
    for (int k = 0; k < 8; k++) begin
      t = t * 18'd3 + {2'b00, x};
      t = t + 18'(k) + 18'd1;
      c = c + t;
    end
    return c;
  endfunction

  // ---------------- edge / pulse monitor ----------------
  int edge_n = 0;
  int acc_q[$];
  int n_ldt, n_ldc, n_cntup, n_ldx;
  logic clr_cnt = 1'b0;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (start && in_ready && !rst) acc_q.push_back(edge_n);
    if (clr_cnt) begin
      n_ldt = 0; n_ldc = 0; n_cntup = 0; n_ldx = 0;
    end else begin
      n_ldt   = n_ldt   + int'(ldT);
      n_ldc   = n_ldc   + int'(ldC);
      n_cntup = n_cntup + int'(cntUp);
      n_ldx   = n_ldx   + int'(ldX);
    end
  end

  // ---------------- scoreboard / checking ----------------
  logic [R_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {ldX, init0, initT1, initC1, ldT, selXR, ldC, cntUp};
  endfunction

  logic           xbus_chk;
  logic [X_W-1:0] xbus_exp;
  logic           toggle_x;

  // Waits (bounded) for out_valid, sampling on falling edges.
  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (toggle_x && n == 3) x_in = 16'hFFFF;
      if (xbus_chk) check("xbus_hold", 32'(xBus), 32'(xbus_exp));
    end
    if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Compares the result at a handshake edge and lets the edge pass.
  task automatic take_result(input string tag);
    logic [R_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(result), 32'(e));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [R_W-1:0] prev;
    int n;
    int sel_seen;
    rst = 1'b1; start = 1'b0; x_in = '0; abort = 1'b0; out_ready = 1'b0;
    xbus_chk = 1'b0; xbus_exp = '0; toggle_x = 1'b0;
    clr_cnt = 1'b1;
    #23 rst = 1'b0;

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_strobes", 32'(strobes()), 32'd0);
    end

    // Single op x=4000, x_in toggles mid-operation
    clr_cnt = 1'b0;
    start = 1'b1; x_in = 16'h4000;
    exp_q.push_back(model_r(16'h4000));
    @(negedge clk);
    start = 1'b0;
    check("accept", 32'(busy), 32'd1);
    xbus_chk = 1'b1; xbus_exp = 16'h4000; toggle_x = 1'b1;
    wait_valid();
    xbus_chk = 1'b0; toggle_x = 1'b0;
    check("latency", 32'(edge_n - acc_q[$]), 32'd26);
    check("n_ldT", 32'(n_ldt), 32'd16);
    check("n_ldC", 32'(n_ldc), 32'd8);
    check("n_cntUp", 32'(n_cntup), 32'd7);
    check("n_ldX", 32'(n_ldx), 32'd1);

    // Backpressure: hold in VALID for 20 cycles, start pulses ignored
    n = acc_q.size();
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      x_in = 16'(i * 16'h0111);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'(exp_q[0]));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    start = 1'b0;
    check("bp_no_accept", 32'(acc_q.size()), 32'(n));
    take_result("result_4000");
    out_ready = 1'b0;

    // Abort in MULC of term 3
    prev = model_r(16'h4000);
    start = 1'b1; x_in = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    sel_seen = 0;
    n = 0;
    while (sel_seen < 3 && n < 100) begin
      if (selXR) sel_seen++;
      if (sel_seen < 3) begin @(negedge clk); n++; end
    end
    check("abort_reached_mulc", 32'(sel_seen), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_strobes", 32'(strobes()), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'(prev));
    start = 1'b1; x_in = 16'h0100;
    exp_q.push_back(model_r(16'h0100));
    @(negedge clk);
    start = 1'b0;
    check("post_abort_load", 32'(strobes()), 32'h00F0);
    wait_valid();
    take_result("result_0100");
    out_ready = 1'b0;

    // Async reset mid-ACC, between edges
    start = 1'b1; x_in = 16'h0777;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ldC && n < 100) begin @(negedge clk); n++; end
    check("reached_acc", 32'(ldC), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_strobes", 32'(strobes()), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_state", 32'(state_dbg), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    start = 1'b1; x_in = 16'h0000;
    exp_q.push_back(model_r(16'h0000));
    @(negedge clk);
    wait_valid();
    if (exp_q.size() != 0) check("b2b_first", 32'(result), 32'(exp_q.pop_front()));
    else check("sb_empty", 32'd1, 32'd0);
    x_in = 16'h2000;
    exp_q.push_back(model_r(16'h2000));
    n = acc_q.size();
    @(negedge clk);
    check("b2b_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accept", 32'(acc_q.size()), 32'(n + 1));
    if (acc_q.size() >= 2)
      check("b2b_spacing", 32'(acc_q[$] - acc_q[$-1]), 32'd28);
    wait_valid();
    take_result("b2b_second");
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
